// File: rtl/vfu_pkg.sv
// vfu_pkg: shared types and constants for the vector FU arbiter.
//   - opcode constants for the 4-lane vector FU
//   - vec_t: four 32-bit lanes, lane 0 first
//   - state_e: arbiter FSM states
//   - is_illegal(): opcode class helper (1xx opcodes are undefined)
package vfu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef logic [0:3][31:0] vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // Any opcode with the top bit set has no defined FU operation.
    function automatic logic is_illegal(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/vfu_arbiter_rr.sv
// rr_arbiter: combinational rotate-priority pick.
//   req_i [N]   : requesters asking for service
//   ptr_i [PW]  : index holding the highest priority this cycle
//   gnt_o [N]   : one-hot grant (all zero when nothing requests)
// The search starts at ptr_i and wraps upward, so the requester just
// after the previously served one is considered first.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found_s;
    logic [PW-1:0] idx_s;

    // Walk the requesters from ptr_i with wrap and grant the first one set.
    always_comb begin
        gnt_o   = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = PW'((int'(ptr_i) + k) % N);
            if (!found_s && req_i[idx_s]) begin
                gnt_o[idx_s] = 1'b1;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/vfu_arbiter.sv
// vfu_arbiter: shares one combinational 4-lane vector FU among NREQ requesters.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   req_valid_i/ready_o  : per-requester issue handshake (ready is one-hot, IDLE only)
//   req_op_i, req_a_i/b_i: per-requester opcode and operand vectors
//   rsp_valid_o/ready_i  : per-requester result handshake (valid is one-hot)
//   rsp_result_o         : shared result bus, held from RESP entry to handshake
//   rsp_divz_o           : per-lane divide-by-zero flags (lane l -> bit l)
//   rsp_illegal_o        : opcode was 1xx, result forced to zero
//   fu_op_o, fu_a_o/b_o  : latched operands to the external FU
//   fu_result_i          : FU result, sampled after the per-opcode wait
//   busy_o               : FSM is not idle
module vfu_arbiter
    import vfu_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DIV_CYCLES = 4,
    parameter int ALU_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ-1:0][2:0]  req_op_i,
    input  vec_t [NREQ-1:0]       req_a_i,
    input  vec_t [NREQ-1:0]       req_b_i,
    output logic [NREQ-1:0]       rsp_valid_o,
    input  logic [NREQ-1:0]       rsp_ready_i,
    output vec_t                  rsp_result_o,
    output logic [3:0]            rsp_divz_o,
    output logic                  rsp_illegal_o,
    output logic [2:0]            fu_op_o,
    output vec_t                  fu_a_o,
    output vec_t                  fu_b_o,
    input  vec_t                  fu_result_i,
    output logic                  busy_o
);

    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MAXC  = (DIV_CYCLES > ALU_CYCLES) ? DIV_CYCLES : ALU_CYCLES;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [2:0]        op_q, op_d;
    vec_t              a_q, a_d;
    vec_t              b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    vec_t              result_q, result_d;
    logic [3:0]        divz_q, divz_d;
    logic              illegal_q, illegal_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   gnt_s;
    logic [PW-1:0]     gnt_idx_s;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .req_i (req_valid_i),
        .ptr_i (ptr_q),
        .gnt_o (gnt_s)
    );

    // Encode the one-hot grant into an index; OR-ing is safe because gnt_s is one-hot.
    always_comb begin
        gnt_idx_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_idx_s = gnt_idx_s | (gnt_s[i] ? PW'(i) : PW'(0));
        end
    end

    // Next-state, operand latching, result capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        divz_d      = divz_q;
        illegal_d   = illegal_q;
        req_ready_o = '0;

        case (state_q)
            IDLE: begin
                if (|gnt_s) begin
                    req_ready_o = gnt_s;
                    gidx_d      = gnt_idx_s;
                    op_d        = req_op_i[gnt_idx_s];
                    a_d         = req_a_i[gnt_idx_s];
                    b_d         = req_b_i[gnt_idx_s];
                    cnt_d       = (req_op_i[gnt_idx_s] == OP_DIV) ? CNT_W'(DIV_CYCLES - 1)
                                                                  : CNT_W'(ALU_CYCLES - 1);
                    state_d     = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    // Illegal ops and zero-divisor lanes are forced to zero
                    // regardless of what the FU produced.
                    for (int l = 0; l < 4; l++) begin
                        if (is_illegal(op_q)) begin
                            result_d[l] = 32'd0;
                            divz_d[l]   = 1'b0;
                        end else if ((op_q == OP_DIV) && (b_q[l] == 32'd0)) begin
                            result_d[l] = 32'd0;
                            divz_d[l]   = 1'b1;
                        end else begin
                            result_d[l] = fu_result_i[l];
                            divz_d[l]   = 1'b0;
                        end
                    end
                    illegal_d = is_illegal(op_q);
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // Only the granted requester's ready bit completes the response.
                if (rsp_ready_i[gidx_q]) begin
                    state_d = IDLE;
                    if (int'(gidx_q) == NREQ - 1) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gidx_q + PW'(1);
                    end
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        if (state_d == RESP) begin
            rsp_valid_d = ONE_HOT0 << gidx_d;
        end else begin
            rsp_valid_d = '0;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            op_q        <= 3'b000;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            divz_q      <= 4'b0000;
            illegal_q   <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            divz_q      <= divz_d;
            illegal_q   <= illegal_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign fu_op_o       = op_q;
    assign fu_a_o        = a_q;
    assign fu_b_o        = b_q;
    assign rsp_result_o  = result_q;
    assign rsp_divz_o    = divz_q;
    assign rsp_illegal_o = illegal_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_vfu_arbiter.sv
// Directed bench for vfu_arbiter (NREQ=2, DIV_CYCLES=4, ALU_CYCLES=1).
// Inputs change 2 ns after a rising edge; outputs are checked 1 ns later.
module tb_vfu_arbiter;
    import vfu_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_op = '0;
    vec_t [1:0]       req_a = '0;
    vec_t [1:0]       req_b = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = 2'b00;
    vec_t             rsp_result;
    logic [3:0]       rsp_divz;
    logic             rsp_illegal;
    logic [2:0]       fu_op;
    vec_t             fu_a, fu_b, fu_result;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vfu_arbiter #(.NREQ(2), .DIV_CYCLES(4), .ALU_CYCLES(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_divz_o(rsp_divz), .rsp_illegal_o(rsp_illegal),
        .fu_op_o(fu_op), .fu_a_o(fu_a), .fu_b_o(fu_b), .fu_result_i(fu_result),
        .busy_o(busy)
    );

    // Behavioural model of the external combinational vector FU.
    always_comb begin
        fu_result = '0;
        for (int l = 0; l < 4; l++) begin
            case (fu_op)
                3'b000:  fu_result[l] = fu_a[l] + fu_b[l];
                3'b001:  fu_result[l] = fu_a[l] - fu_b[l];
                3'b010:  fu_result[l] = fu_a[l] * fu_b[l];
                3'b011:  fu_result[l] = (fu_b[l] == 32'd0) ? 32'd0 : fu_a[l] / fu_b[l];
                default: fu_result[l] = 32'd0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_req_ready", 128'(req_ready), 128'(2'b00));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(2'b00));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_result", rsp_result, 128'd0);
        chk("rst_divz", 128'(rsp_divz), 128'(4'b0000));
        chk("rst_illegal", 128'(rsp_illegal), 128'(1'b0));
        chk("rst_fu_op", 128'(fu_op), 128'(3'b000));
        chk("rst_fu_a", fu_a, 128'd0);
        chk("rst_fu_b", fu_b, 128'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Single ADD from requester 0
        cyc();
        req_valid = 2'b01; req_op[0] = OP_ADD; rsp_ready = 2'b11;
        req_a[0] = {32'd1, 32'd2, 32'd3, 32'd4};
        req_b[0] = {32'd10, 32'd20, 32'd30, 32'd40};
        #1;
        chk("add_ready_c0", 128'(req_ready), 128'(2'b01));
        cyc(); req_valid = 2'b00; #1;
        chk("add_busy_c1", 128'(busy), 128'(1'b1));
        chk("add_noresp_c1", 128'(rsp_valid), 128'(2'b00));
        chk("add_fu_op", 128'(fu_op), 128'(3'b000));
        chk("add_fu_a", fu_a, {32'd1, 32'd2, 32'd3, 32'd4});
        cyc(); #1;
        chk("add_valid_c2", 128'(rsp_valid), 128'(2'b01));
        chk("add_result", rsp_result, {32'd11, 32'd22, 32'd33, 32'd44});
        chk("add_illegal", 128'(rsp_illegal), 128'(1'b0));
        cyc(); #1;
        chk("add_idle_c3", 128'(busy), 128'(1'b0));
        chk("add_valid_drop", 128'(rsp_valid), 128'(2'b00));

        // Divide with a zero lane from requester 1
        cyc();
        req_valid = 2'b10; req_op[1] = OP_DIV;
        req_a[1] = {32'd100, 32'd7, 32'd9, 32'hFFFFFFFF};
        req_b[1] = {32'd10, 32'd0, 32'd3, 32'd1};
        #1;
        chk("div_ready_c0", 128'(req_ready), 128'(2'b10));
        for (int c = 1; c <= 4; c++) begin
            cyc();
            req_valid = 2'b00;
            #1;
            chk("div_wait", 128'(rsp_valid), 128'(2'b00));
        end
        cyc(); #1;
        chk("div_valid_c5", 128'(rsp_valid), 128'(2'b10));
        chk("div_result", rsp_result, {32'd10, 32'd0, 32'd3, 32'hFFFFFFFF});
        chk("div_divz", 128'(rsp_divz), 128'(4'b0010));
        cyc(); #1;
        chk("div_idle", 128'(busy), 128'(1'b0));

        // Contention: grants 0,1,0,1 three cycles apart
        cyc();
        req_valid = 2'b11; req_op[0] = OP_ADD; req_op[1] = OP_ADD;
        req_a[1] = {32'd1, 32'd1, 32'd1, 32'd1};
        req_b[1] = {32'd2, 32'd2, 32'd2, 32'd2};
        for (int c = 0; c < 10; c++) begin
            logic [1:0] exp_g;
            if (c > 0) cyc();
            #1;
            exp_g = (c % 3 != 0) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_grant", 128'(req_ready), 128'(exp_g));
        end
        cyc(); req_valid = 2'b00;
        cyc(); cyc(); #1;
        chk("rr_idle", 128'(busy), 128'(1'b0));

        // Back-pressure on a truncating MUL; the other requester's ready bit is ignored
        cyc();
        req_valid = 2'b01; req_op[0] = OP_MUL; rsp_ready = 2'b10;
        req_a[0] = {32'h00010000, 32'd2, 32'd3, 32'd4};
        req_b[0] = {32'h00010000, 32'd5, 32'd6, 32'd7};
        #1;
        chk("bp_ready_c0", 128'(req_ready), 128'(2'b01));
        cyc(); req_valid = 2'b10; #1;
        chk("bp_exec_noready", 128'(req_ready), 128'(2'b00));
        for (int c = 2; c <= 6; c++) begin
            cyc(); #1;
            chk("bp_hold_valid", 128'(rsp_valid), 128'(2'b01));
            chk("bp_hold_result", rsp_result, {32'd0, 32'd10, 32'd18, 32'd28});
            chk("bp_no_accept", 128'(req_ready), 128'(2'b00));
        end
        cyc(); rsp_ready = 2'b01; #1;
        chk("bp_valid_c7", 128'(rsp_valid), 128'(2'b01));
        cyc(); #1;
        chk("bp_next_grant", 128'(req_ready), 128'(2'b10));
        chk("bp_valid_clr", 128'(rsp_valid), 128'(2'b00));
        cyc(); req_valid = 2'b00; rsp_ready = 2'b11;
        cyc(); #1;
        chk("bp_r1_valid", 128'(rsp_valid), 128'(2'b10));
        chk("bp_r1_result", rsp_result, {32'd3, 32'd3, 32'd3, 32'd3});
        cyc(); #1;
        chk("bp_idle", 128'(busy), 128'(1'b0));

        // Illegal opcode
        cyc();
        req_valid = 2'b01; req_op[0] = 3'b101;
        req_a[0] = {32'd1, 32'd2, 32'd3, 32'd4};
        req_b[0] = {32'd5, 32'd6, 32'd7, 32'd8};
        #1;
        chk("ill_ready", 128'(req_ready), 128'(2'b01));
        cyc(); req_valid = 2'b00; #1;
        chk("ill_c1", 128'(rsp_valid), 128'(2'b00));
        cyc(); #1;
        chk("ill_valid_c2", 128'(rsp_valid), 128'(2'b01));
        chk("ill_result", rsp_result, 128'd0);
        chk("ill_flag", 128'(rsp_illegal), 128'(1'b1));
        chk("ill_divz", 128'(rsp_divz), 128'(4'b0000));
        cyc(); #1;
        chk("ill_idle", 128'(busy), 128'(1'b0));

        // Reset in the second EXEC cycle of a divide (pointer sits at 1 here)
        cyc();
        req_valid = 2'b10; req_op[1] = OP_DIV;
        req_a[1] = {32'd50, 32'd60, 32'd70, 32'd80};
        req_b[1] = {32'd5, 32'd6, 32'd7, 32'd8};
        #1;
        chk("rdiv_ready", 128'(req_ready), 128'(2'b10));
        cyc(); req_valid = 2'b00; #1;
        chk("rdiv_busy", 128'(busy), 128'(1'b1));
        cyc(); rst = 1'b1; #1;
        chk("rdiv_busy_clr", 128'(busy), 128'(1'b0));
        chk("rdiv_valid_clr", 128'(rsp_valid), 128'(2'b00));
        chk("rdiv_fu_op_clr", 128'(fu_op), 128'(3'b000));
        chk("rdiv_fu_a_clr", fu_a, 128'd0);
        chk("rdiv_fu_b_clr", fu_b, 128'd0);
        chk("rdiv_illegal_clr", 128'(rsp_illegal), 128'(1'b0));
        chk("rdiv_result_clr", rsp_result, 128'd0);
        cyc();
        cyc(); rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            cyc(); #1;
            chk("rdiv_no_resp", 128'(rsp_valid), 128'(2'b00));
        end
        cyc();
        req_valid = 2'b11; req_op[0] = OP_ADD; req_op[1] = OP_ADD;
        #1;
        chk("rdiv_ptr0", 128'(req_ready), 128'(2'b01));
        cyc(); req_valid = 2'b00;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
